dmem_responder: RTL and testbench

//  Data-memory responder: the memory end of the load/store control signals (mem_rw, mem_size, mem_sign).

---
 rtl/dmem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder -- data-memory responder for the load/store path.
//
// Takes one request at a time from the ALU-address/rs2 side and performs a
// byte, halfword or word access on byte-lane storage. The response goes to
// the writeback mux LATENCY cycles later. Loads are sign- or zero-extended.
// Store data arrives right-justified and is steered onto the lanes selected
// by the address.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high
//   req_valid   request present          req_ready   responder can accept (IDLE)
//   req_addr    byte address             req_wdata   store data, right-justified
//   req_rw      0 read / 1 write         req_size    00 B, 01 H, 10 W, 11 illegal
//   req_sign    1 sign-extend load       resp_valid  response present (RESP)
//   resp_ready  consumer takes response  resp_rdata  extended load data, else 0
//   resp_err    misaligned, illegal size or out-of-range access

// One byte lane of storage. The read is asynchronous, so a load sees the
// word as it stands on its accept edge, including any store accepted earlier.
module dmem_lane #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH];

  // Storage is never cleared by reset.
  always_ff @(posedge clock)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int          NUM_LANES = 4;
  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic        rw;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  req_t   req;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  resp_t  pend_q, pend_d;   // response captured at accept, waiting out the latency
  resp_t  resp_q, resp_d;   // response presented to the consumer

  logic [31:0] off;
  logic        misal, oor, err, accept, do_wr;
  logic [IDX_W-1:0] idx;
  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_wd;
  logic [NUM_LANES-1:0][7:0] lane_rd;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  resp_t       rsp_new;

  assign req = '{rw: req_rw, size: req_size, sign: req_sign,
                 addr: req_addr, wdata: req_wdata};

  // ---------------------------------------------------------------- decode
  assign off    = req.addr - BASE_ADDR;
  // Zero-extend before comparing so 4*DEPTH_WORDS cannot wrap.
  assign oor    = (req.addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
  assign misal  = ((req.size == 2'b01) && req.addr[0]) ||
                  ((req.size == 2'b10) && (req.addr[1:0] != 2'b00));
  assign err    = misal || (req.size == 2'b11) || oor;
  assign idx    = off[IDX_W+1:2];
  assign accept = req_valid && (state_q == IDLE);
  // Reset wins over a coincident accept, so it also blocks the write.
  assign do_wr  = accept && req.rw && !err && !reset;

  // ------------------------------------------------------------ byte lanes
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);

    always_comb begin
      lane_we[i] = 1'b0;
      lane_wd[i] = req.wdata[8*i +: 8];
      case (req.size)
        2'b00: begin
          lane_we[i] = do_wr && (req.addr[1:0] == LANE);
          lane_wd[i] = req.wdata[7:0];
        end
        2'b01: begin
          lane_we[i] = do_wr && (req.addr[1] == LANE[1]);
          lane_wd[i] = req.wdata[8*(i%2) +: 8];
        end
        default: lane_we[i] = do_wr;
      endcase
    end

    dmem_lane #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W)) u_lane (
      .clock (clock),
      .we    (lane_we[i]),
      .idx   (idx),
      .wdata (lane_wd[i]),
      .rdata (lane_rd[i])
    );
  end

  // ------------------------------------------------------ load extraction
  always_comb begin
    ld_byte = lane_rd[req.addr[1:0]];
    ld_half = req.addr[1] ? lane_rd[3:2] : lane_rd[1:0];
    case (req.size)
      2'b00:   ld_val = {{24{req.sign & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{req.sign & ld_half[15]}}, ld_half};
      default: ld_val = lane_rd;
    endcase
    // Stores and faulting accesses return zero data.
    if (err || req.rw) ld_val = '0;
    rsp_new = '{err: err, rdata: ld_val};
  end

  // ------------------------------------------------------------------ FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pend_d = rsp_new;
          if (LATENCY == 1) begin
            state_d = RESP;
            resp_d  = rsp_new;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
          resp_d  = pend_q;
        end
      end
      RESP: begin
        // Data and err stay put until the consumer takes them.
        if (resp_ready) begin
          state_d = IDLE;
          resp_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        resp_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      resp_q  <= resp_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_q.rdata;
  assign resp_err   = resp_q.err;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int          DW   = 1024;
  localparam int          LAT  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_rw = 1'b0, req_sign = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;

  int n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rw(req_rw), .req_size(req_size), .req_sign(req_sign),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference memory: flat byte array indexed by offset from BASE.
  logic [7:0] mdl [4*DW];

  function automatic void model_op(input logic rw, input logic [1:0] size, input logic sign,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   output logic [31:0] rd, output logic err);
    longint off, v;
    int n;
    off = longint'(addr) - longint'(BASE);
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0) ||
          off < 0 || off >= 4 * DW;
    rd = '0;
    if (err) return;
    n = 1 << size;
    if (rw) begin
      for (int b = 0; b < n; b++) mdl[int'(off) + b] = 8'(wdata >> (8 * b));
    end else begin
      v = 0;
      for (int b = 0; b < n; b++) v += longint'(mdl[int'(off) + b]) << (8 * b);
      if (sign && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      rd = 32'(v);
    end
  endfunction

  // One full transaction. hold = cycles resp_ready stays low in RESP, during
  // which a stray store is offered and must be ignored.
  task automatic do_req(input logic rw, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rd, output logic e, output int lat);
    @(negedge clock);
    chk("req_ready in idle", req_ready, 1);
    req_rw = rw; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom); req_sign = 1'($urandom);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rd = resp_rdata;
    e  = resp_err;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10;
      req_addr = BASE + 32'h10; req_wdata = 32'h0BAD_F00D;
      @(negedge clock);
      chk("hold resp_valid", resp_valid, 1);
      chk("hold rdata", resp_rdata, rd);
      chk("hold err", resp_err, e);
      chk("hold req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk("resp_valid after take", resp_valid, 0);
  endtask

  typedef struct {
    string       name;
    logic        rw;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic rw, input logic [1:0] sz, input logic sg,
                     input logic [31:0] off, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = nm; v.rw = rw; v.size = sz; v.sign = sg; v.addr = BASE + off;
    v.wdata = wd; v.exp_rd = er; v.exp_err = ee;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] rd, exp_rd;
    logic        e, exp_e;
    int          lat;

    // ------------------------------------------------------- reset state
    #2;
    chk("reset req_ready", req_ready, 1);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset rdata", resp_rdata, 0);
    chk("reset err", resp_err, 0);
    #20;
    @(negedge clock);
    reset = 1'b0;

    // ------------------------------------------------------------- table
    add("sw deadbeef",  1, 2'b10, 0, 32'h10,  32'hDEAD_BEEF, 32'h0,         0);
    add("lw 0x10",      0, 2'b10, 0, 32'h10,  32'h0,         32'hDEAD_BEEF, 0);
    add("sb 80",        1, 2'b00, 0, 32'h13,  32'hFFFF_FF80, 32'h0,         0);
    add("lb 0x13",      0, 2'b00, 1, 32'h13,  32'h0,         32'hFFFF_FF80, 0);
    add("lbu 0x13",     0, 2'b00, 0, 32'h13,  32'h0,         32'h0000_0080, 0);
    add("lw after sb",  0, 2'b10, 1, 32'h10,  32'h0,         32'h80AD_BEEF, 0);
    add("sh misalign",  1, 2'b01, 0, 32'h11,  32'h1234,      32'h0,         1);
    add("lw unchanged", 0, 2'b10, 0, 32'h10,  32'h0,         32'h80AD_BEEF, 0);
    add("sw size11",    1, 2'b11, 0, 32'h10,  32'h0,         32'h0,         1);
    add("lw size11",    0, 2'b11, 0, 32'h10,  32'h0,         32'h0,         1);
    add("lw unchanged2",0, 2'b10, 0, 32'h10,  32'h0,         32'h80AD_BEEF, 0);
    add("lw top+1",     0, 2'b10, 0, 32'h1000,32'h0,         32'h0,         1);
    add("lw below",     0, 2'b10, 0, -32'sd4, 32'h0,         32'h0,         1);
    add("lw misalign",  0, 2'b10, 0, 32'h12,  32'h0,         32'h0,         1);
    add("sw 80017fff",  1, 2'b10, 0, 32'h10,  32'h8001_7FFF, 32'h0,         0);
    add("lh 0x12",      0, 2'b01, 1, 32'h12,  32'h0,         32'hFFFF_8001, 0);
    add("lhu 0x12",     0, 2'b01, 0, 32'h12,  32'h0,         32'h0000_8001, 0);
    add("lh 0x10",      0, 2'b01, 1, 32'h10,  32'h0,         32'h0000_7FFF, 0);
    add("sw last word", 1, 2'b10, 0, 32'hFFC, 32'hA5A5_5A5A, 32'h0,         0);
    add("lw last word", 0, 2'b10, 0, 32'hFFC, 32'h0,         32'hA5A5_5A5A, 0);

    foreach (tbl[i]) begin
      do_req(tbl[i].rw, tbl[i].size, tbl[i].sign, tbl[i].addr, tbl[i].wdata, 0, rd, e, lat);
      chk({tbl[i].name, " rdata"}, rd, tbl[i].exp_rd);
      chk({tbl[i].name, " err"}, e, tbl[i].exp_err);
      chk({tbl[i].name, " latency"}, lat, LAT);
    end

    // --------------------------------------- consumer stall, stray request
    do_req(0, 2'b10, 0, BASE + 32'h10, 0, 3, rd, e, lat);
    chk("stall lw rdata", rd, 32'h8001_7FFF);
    do_req(0, 2'b10, 0, BASE + 32'h10, 0, 0, rd, e, lat);
    chk("stray store ignored", rd, 32'h8001_7FFF);

    // ------------------------------------------------- reset during WAIT
    @(negedge clock);
    req_rw = 1; req_size = 2'b10; req_addr = BASE + 32'h20; req_wdata = 32'h55; req_valid = 1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("rst wait resp_valid", resp_valid, 0);
    chk("rst wait req_ready", req_ready, 1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("post rst resp_valid", resp_valid, 0);
      chk("post rst req_ready", req_ready, 1);
    end
    do_req(0, 2'b10, 0, BASE + 32'h20, 0, 0, rd, e, lat);
    chk("committed store kept", rd, 32'h55);

    // ------------------------------------- reset coincident with accept
    do_req(1, 2'b10, 0, BASE + 32'h24, 32'h11, 0, rd, e, lat);
    @(negedge clock);
    req_rw = 1; req_size = 2'b10; req_addr = BASE + 32'h24; req_wdata = 32'h77; req_valid = 1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst+accept resp_valid", resp_valid, 0);
    end
    do_req(0, 2'b10, 0, BASE + 32'h24, 0, 0, rd, e, lat);
    chk("rst+accept no write", rd, 32'h11);

    // ------------------------------------------ randomized vs reference
    for (int w = 0; w < 64; w++) begin
      logic [31:0] d;
      d = $urandom;
      model_op(1, 2'b10, 0, BASE + 32'(4 * w), d, exp_rd, exp_e);
      do_req(1, 2'b10, 0, BASE + 32'(4 * w), d, 0, rd, e, lat);
    end
    for (int t = 0; t < 200; t++) begin
      logic        rw, sg;
      logic [1:0]  sz;
      logic [31:0] a, d;
      int          r;
      rw = 1'($urandom);
      sg = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r  = $urandom_range(0, 9);
      if (r == 0)      a = BASE - 32'($urandom_range(1, 16));
      else if (r == 1) a = BASE + 32'h1000 + 32'($urandom_range(0, 64));
      else             a = BASE + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      d = $urandom;
      model_op(rw, sz, sg, a, d, exp_rd, exp_e);
      do_req(rw, sz, sg, a, d, $urandom_range(0, 2), rd, e, lat);
      chk("rand rdata", rd, exp_rd);
      chk("rand err", e, exp_e);
      chk("rand latency", lat, LAT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
